// File: rtl/uart_core_param.sv
// ============================================================================
// uart_core_param
// ----------------------------------------------------------------------------
// Parametrised full-duplex UART core. A free-running 16x baud tick generator
// drives independent RX and TX state machines. Each direction is buffered by
// a first-word-fall-through FIFO. Received frames are checked for parity,
// framing and overrun errors. Echo mode loops received bytes back to the
// transmitter.
//
// Optional feature macro: UART_BREAK_DETECT_EN
//   defined   - an all-zero frame with a low stop sample pulses break_det.
//               RX then waits for 16 ticks of line-high before it accepts a
//               new start bit.
//   undefined - break_det is tied low. Such a frame is reported as a framing
//               error.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   rx, tx          serial line in (asynchronous) / out
//   tx_wdata, tx_wr push a byte into the TX FIFO; tx_full when it is full
//   rx_rdata, rx_rd head of the RX FIFO (FWFT) and pop; rx_empty when empty
//   echo_en         route received bytes straight back to TX
//   tx_busy         a frame is being shifted out
//   rx_parity_err, rx_frame_err, rx_overrun, break_det   one-cycle pulses
// ============================================================================

// ----------------------------------------------------------------------------
// uart_core_param_fifo: first-word-fall-through FIFO.
//   push/wdata  write side (ignored when full unless a pop happens together)
//   pop/rdata   read side; rdata shows the head entry, or 0 when empty
//   full/empty  occupancy flags
// ----------------------------------------------------------------------------
module uart_core_param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A pop on a full FIFO frees the slot, so a simultaneous push is accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr];

    // The DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end
endmodule

// ----------------------------------------------------------------------------
// uart_core_param: top level.
// ----------------------------------------------------------------------------
module uart_core_param #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_wdata,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic [DATA_BITS-1:0] rx_rdata,
    input  logic                 rx_rd,
    output logic                 rx_empty,
    input  logic                 echo_en,
    output logic                 tx_busy,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 break_det
);
    localparam int BAUD_DIV = CLK_HZ / (BAUD * 16);
    localparam int BD_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

    // ---------------- baud tick generator ----------------
    logic [BD_W-1:0] baud_cnt;
    logic            b_tick;

    assign b_tick = (baud_cnt == BD_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (b_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + BD_W'(1);
        end
    end

    // ---------------- rx synchroniser (idles high) ----------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------- FIFOs and echo routing ----------------
    logic                 tx_push;
    logic [DATA_BITS-1:0] tx_push_data;
    logic                 tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_empty;
    logic                 rx_push;
    logic                 rx_pop;
    logic                 rx_full;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 echo_move;

    // In echo mode the user strobes are ignored and one byte moves per cycle.
    assign echo_move    = echo_en && !rx_empty && !tx_full;
    assign tx_push      = echo_en ? echo_move : tx_wr;
    assign tx_push_data = echo_en ? rx_rdata  : tx_wdata;
    assign rx_pop       = echo_en ? echo_move : rx_rd;

    uart_core_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (tx_push_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_core_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // ---------------- RX state machine ----------------
    rx_state_t            rx_state, rx_state_n;
    logic [3:0]           rx_tick, rx_tick_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_shift_n;
    logic                 rx_par, rx_par_n;
    logic                 brk_wait, brk_wait_n;
    logic                 par_err_n, frame_err_n, overrun_n, break_n;
    logic                 par_bad;
    logic                 brk_cond;

    // Odd parity: data plus parity bit hold an odd number of ones.
    assign par_bad = (PARITY == 1) ? (rx_par == ^rx_shift) :
                     (PARITY == 2) ? (rx_par != ^rx_shift) : 1'b0;

`ifdef UART_BREAK_DETECT_EN
    assign brk_cond = (rx_shift == '0) && ((PARITY == 0) || !rx_par);
`else
    assign brk_cond = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_tick       <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par        <= 1'b0;
            brk_wait      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            break_det     <= 1'b0;
        end else begin
            rx_state      <= rx_state_n;
            rx_tick       <= rx_tick_n;
            rx_bit        <= rx_bit_n;
            rx_shift      <= rx_shift_n;
            rx_par        <= rx_par_n;
            brk_wait      <= brk_wait_n;
            rx_parity_err <= par_err_n;
            rx_frame_err  <= frame_err_n;
            rx_overrun    <= overrun_n;
            break_det     <= break_n;
        end
    end

    // Tick counting is shared: mid-bit search in START, full-bit spacing in
    // DATA/PAR/STOP, and the line-high run length while waiting after a break.
    // The stop sample decides the frame's fate in that same cycle: the byte is
    // pushed straight from the shift register, and the error pulses are
    // registered so they appear one cycle later.
    always_comb begin
        rx_state_n  = rx_state;
        rx_tick_n   = rx_tick;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_par_n    = rx_par;
        brk_wait_n  = brk_wait;
        par_err_n   = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
        break_n     = 1'b0;
        rx_push     = 1'b0;

        case (rx_state)
            RX_IDLE: begin
                if (brk_wait) begin
                    if (b_tick) begin
                        if (!rx_s) begin
                            rx_tick_n = '0;
                        end else if (rx_tick == 4'd15) begin
                            rx_tick_n  = '0;
                            brk_wait_n = 1'b0;
                        end else begin
                            rx_tick_n = rx_tick + 4'd1;
                        end
                    end
                end else if (!rx_s) begin
                    rx_state_n = RX_START;
                    rx_tick_n  = '0;
                end
            end
            RX_START: begin
                if (b_tick) begin
                    if (rx_tick == 4'd7) begin
                        if (rx_s) begin
                            rx_state_n = RX_IDLE;
                        end else begin
                            rx_state_n = RX_DATA;
                            rx_tick_n  = '0;
                            rx_bit_n   = '0;
                        end
                    end else begin
                        rx_tick_n = rx_tick + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (b_tick) begin
                    if (rx_tick == 4'd15) begin
                        rx_tick_n  = '0;
                        rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == 3'(DATA_BITS - 1)) begin
                            rx_state_n = (PARITY != 0) ? RX_PAR : RX_STOP;
                        end else begin
                            rx_bit_n = rx_bit + 3'd1;
                        end
                    end else begin
                        rx_tick_n = rx_tick + 4'd1;
                    end
                end
            end
            RX_PAR: begin
                if (b_tick) begin
                    if (rx_tick == 4'd15) begin
                        rx_tick_n  = '0;
                        rx_par_n   = rx_s;
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_tick_n = rx_tick + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (b_tick) begin
                    if (rx_tick == 4'd15) begin
                        rx_tick_n  = '0;
                        rx_state_n = RX_IDLE;
                        if (!rx_s) begin
                            if (brk_cond) begin
                                break_n    = 1'b1;
                                brk_wait_n = 1'b1;
                            end else begin
                                frame_err_n = 1'b1;
                            end
                        end else if (par_bad) begin
                            par_err_n = 1'b1;
                        end else if (rx_full && !rx_pop) begin
                            overrun_n = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                        end
                    end else begin
                        rx_tick_n = rx_tick + 4'd1;
                    end
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // ---------------- TX state machine ----------------
    tx_state_t            tx_state, tx_state_n;
    logic [4:0]           tx_tick, tx_tick_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_par, tx_par_n;
    logic                 tx_next;

    assign tx_busy = (tx_state != TX_IDLE);

    // tx is a register that resets to the idle level, so a reset drives the
    // line high immediately, even in the middle of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx       <= tx_next;
        end
    end

    // The parity bit is computed once, when the byte is loaded, because the
    // shift register is consumed as the bits go out. The line level is
    // derived from the next state so it changes on the same edge as the FSM.
    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_pop     = 1'b0;

        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_par_n   = (PARITY == 1) ? ~^tx_head : ^tx_head;
                    tx_tick_n  = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (b_tick) begin
                    if (tx_tick == 5'd15) begin
                        tx_tick_n  = '0;
                        tx_bit_n   = '0;
                        tx_state_n = TX_DATA;
                    end else begin
                        tx_tick_n = tx_tick + 5'd1;
                    end
                end
            end
            TX_DATA: begin
                if (b_tick) begin
                    if (tx_tick == 5'd15) begin
                        tx_tick_n  = '0;
                        tx_shift_n = tx_shift >> 1;
                        if (tx_bit == 3'(DATA_BITS - 1)) begin
                            tx_state_n = (PARITY != 0) ? TX_PAR : TX_STOP;
                        end else begin
                            tx_bit_n = tx_bit + 3'd1;
                        end
                    end else begin
                        tx_tick_n = tx_tick + 5'd1;
                    end
                end
            end
            TX_PAR: begin
                if (b_tick) begin
                    if (tx_tick == 5'd15) begin
                        tx_tick_n  = '0;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_tick_n = tx_tick + 5'd1;
                    end
                end
            end
            TX_STOP: begin
                if (b_tick) begin
                    if (tx_tick == 5'(STOP_BITS * 16 - 1)) begin
                        tx_tick_n  = '0;
                        tx_state_n = TX_IDLE;
                    end else begin
                        tx_tick_n = tx_tick + 5'd1;
                    end
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase

        case (tx_state_n)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = tx_shift_n[0];
            TX_PAR:   tx_next = tx_par_n;
            default:  tx_next = 1'b1;
        endcase
    end
endmodule
